// File: rtl/rv_pkg.sv
// rv_pkg: shared GPR-file definitions for the writeback path.
//   XLEN     - datapath width
//   REG_AW   - register address width
//   NUM_REGS - number of architectural GPRs (x0 hard-wired to zero)
//   wb_req_t - one writeback request: destination register + data
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_chk.sv
// regfile_wb_ctrl_chk: protocol checks for the writeback controller.
// Ports:
//   clk, srst_n  - clock, synchronous active-low reset
//   alu_hold     - controller's registered hold request
//   alu_wb_valid - ALU writeback valid from the pipeline
module regfile_wb_ctrl_chk (
  input logic clk,
  input logic srst_n,
  input logic alu_hold,
  input logic alu_wb_valid
);

  // The pipeline must not present an ALU result while hold is asserted.
  a_no_alu_during_hold: assert property (
    @(posedge clk) disable iff (!srst_n) !(alu_hold && alu_wb_valid)
  );

endmodule

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests used to buffer load returns.
// Ports:
//   clk, srst_n      - clock, synchronous active-low reset (empties the FIFO)
//   push_i, din_i    - write request; ignored while full
//   pop_i            - consume the head entry; ignored while empty
//   dout_o           - head entry (valid when !empty_o)
//   full_o, empty_o  - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    srst_n,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wb_req_t     mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push_s;
  logic        do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller of the 32x32 GPR file.
// Merges ALU and load writebacks onto the single regfile write port and keeps a
// busy scoreboard of in-flight destinations for decode hazard detection.
// Ports:
//   clk, srst_n                      - clock, synchronous active-low reset
//   iss_valid/iss_rd/iss_ready       - decode issue of a register-writing instr
//   chk_rs1/chk_rs2/hazard           - decode source hazard query
//   alu_wb_valid/alu_wb_rd/_data     - ALU writeback (no backpressure)
//   alu_hold                         - registered request to skip ALU writeback
//   ld_wb_valid/ld_wb_rd/_data/ready - load writeback, buffered in a FIFO
//   wen/waddr/wdata                  - registered regfile write port
//   busy_vec                         - scoreboard, bit 0 always 0
module regfile_wb_ctrl
  import rv_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                clk,
  input  logic                srst_n,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rd,
  output logic                iss_ready,
  input  logic [REG_AW-1:0]   chk_rs1,
  input  logic [REG_AW-1:0]   chk_rs2,
  output logic                hazard,
  input  logic                alu_wb_valid,
  input  logic [REG_AW-1:0]   alu_wb_rd,
  input  logic [XLEN-1:0]     alu_wb_data,
  output logic                alu_hold,
  input  logic                ld_wb_valid,
  output logic                ld_wb_ready,
  input  logic [REG_AW-1:0]   ld_wb_rd,
  input  logic [XLEN-1:0]     ld_wb_data,
  output logic                wen,
  output logic [REG_AW-1:0]   waddr,
  output logic [XLEN-1:0]     wdata,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(STARVE_LIMIT - 1);
  localparam logic [CW-1:0]       CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] REG_BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask_s, clr_mask_s;
  logic [CW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                alu_hold_q, alu_hold_d;
  logic                wen_q, wen_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                iss_fire_s;
  logic                fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
  logic                grant_valid_s;
  wb_req_t             grant_req_s, fifo_head_s, ld_req_s;

  assign iss_ready   = !((iss_rd != 5'd0) && busy_q[iss_rd]);
  assign hazard      = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
                       ((chk_rs2 != 5'd0) && busy_q[chk_rs2]);
  assign iss_fire_s  = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign ld_wb_ready = !fifo_full_s;
  assign fifo_push_s = ld_wb_valid && !fifo_full_s;
  assign ld_req_s    = '{rd: ld_wb_rd, data: ld_wb_data};

  wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
    .clk     (clk),
    .srst_n  (srst_n),
    .push_i  (fifo_push_s),
    .din_i   (ld_req_s),
    .pop_i   (fifo_pop_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Fixed-priority arbiter: ALU first, then the load FIFO head.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_req_s   = '0;
    fifo_pop_s    = 1'b0;
    if (alu_wb_valid) begin
      grant_valid_s = 1'b1;
      grant_req_s   = '{rd: alu_wb_rd, data: alu_wb_data};
    end else if (!fifo_empty_s) begin
      grant_valid_s = 1'b1;
      grant_req_s   = fifo_head_s;
      fifo_pop_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Starvation tracking: count ALU wins over a waiting load, then request a hold.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    alu_hold_d   = 1'b0;
    if (fifo_empty_s || fifo_pop_s) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q >= CNT_LAST) begin
      // Saturate so a hold-ignoring pipeline keeps getting hold requests.
      alu_hold_d   = 1'b1;
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end
  end

  // Scoreboard update: clear on the regfile capture edge, set wins on collision.
  assign clr_mask_s = wen_q ? (REG_BIT0 << waddr_q) : '0;
  assign set_mask_s = iss_fire_s ? (REG_BIT0 << iss_rd) : '0;
  assign busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~REG_BIT0;

  // Write-port next state; x0 grants are consumed but never written.
  always_comb begin
    wen_d   = grant_valid_s && (grant_req_s.rd != 5'd0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_valid_s) begin
      waddr_d = grant_req_s.rd;
      wdata_d = grant_req_s.data;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      busy_q       <= '0;
      starve_cnt_q <= '0;
      alu_hold_q   <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      alu_hold_q   <= alu_hold_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign alu_hold = alu_hold_q;
  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy_vec = busy_q;

  regfile_wb_ctrl_chk u_chk (
    .clk          (clk),
    .srst_n       (srst_n),
    .alu_hold     (alu_hold_q),
    .alu_wb_valid (alu_wb_valid)
  );

endmodule
